// File: rtl/convolution_controller_if.sv
// Pixel handshake, FIFO control and status bundle for convolution_controller.
// master = controller side, slave = datapath / top-level side.
interface convolution_controller_if;
  logic start;
  logic in_valid;
  logic in_ready;
  logic get_1_pic_done;
  logic conv_done;
  logic ff_in_en;
  logic ff_in_pp;
  logic ff_out_en;
  logic ff_out_pp;
  logic out_ready;
  logic out_valid;
  logic busy;
  logic done;
  logic err;

  modport master (
    input  start, in_valid, get_1_pic_done, conv_done, out_ready,
    output in_ready, ff_in_en, ff_in_pp, ff_out_en, ff_out_pp, out_valid, busy, done, err
  );

  modport slave (
    output start, in_valid, get_1_pic_done, conv_done, out_ready,
    input  in_ready, ff_in_en, ff_in_pp, ff_out_en, ff_out_pp, out_valid, busy, done, err
  );
endinterface

// File: rtl/convolution_controller.sv
// LOAD/CONV/DRAIN sequencer for the convolution FIFO datapath, one image per start.
// Optional busy-cycle counter port cycle_count enabled by defining CONV_CYCLE_CNT_EN.
module convolution_controller #(
  parameter int unsigned IMG_W   = 28,
  parameter int unsigned IMG_H   = 28,
  parameter int unsigned K       = 3,
  parameter int unsigned WIN_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  convolution_controller_if.master bus
`ifdef CONV_CYCLE_CNT_EN
  ,
  output logic [31:0]              cycle_count
`endif
);

  localparam int unsigned PixN = IMG_W * IMG_H;
  localparam int unsigned OutN = (IMG_W - K + 1) * (IMG_H - K + 1);
  localparam int unsigned CntW = $clog2(PixN + 1);

  localparam logic [CntW-1:0] PixMax  = CntW'(PixN);
  localparam logic [CntW-1:0] OutMax  = CntW'(OutN);
  localparam logic [CntW-1:0] ColLast = CntW'(IMG_W - 1);
  localparam logic [CntW-1:0] KEdge   = CntW'(K - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StConv, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   in_cnt_q, in_cnt_d;
  logic [CntW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CntW-1:0]   push_cnt_q, push_cnt_d;
  logic [CntW-1:0]   pop_cnt_q, pop_cnt_d;
  logic              err_q, err_d;
  logic              out_valid_q;

  logic [CntW-1:0]   row_q, col_q;
  logic [WIN_LAT-1:0] dv_q;
  logic [CntW-1:0]   drow_q [WIN_LAT];
  logic [CntW-1:0]   dcol_q [WIN_LAT];

  logic clear, pop_in, pop_out;
  logic in_ready, ff_in_en, ff_in_pp, ff_out_en, ff_out_pp;

  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    push_cnt_d = push_cnt_q;
    pop_cnt_d  = pop_cnt_q;
    err_d      = err_q;
    clear      = 1'b0;
    pop_in     = 1'b0;
    pop_out    = 1'b0;
    in_ready   = 1'b0;
    ff_in_en   = 1'b0;
    ff_in_pp   = 1'b0;
    ff_out_en  = 1'b0;
    ff_out_pp  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StLoad;
          clear      = 1'b1;
          err_d      = 1'b0;
          in_cnt_d   = '0;
          rd_cnt_d   = '0;
          push_cnt_d = '0;
          pop_cnt_d  = '0;
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          ff_in_en = 1'b1;
          ff_in_pp = 1'b1;
          if (in_cnt_q < PixMax) in_cnt_d = in_cnt_q + 1'b1;
          // Last push and the move to CONV share one edge.
          if (in_cnt_d == PixMax) state_d = StConv;
        end
        if (bus.get_1_pic_done && (in_cnt_q < PixMax - 1'b1)) err_d = 1'b1;
      end
      StConv: begin
        if (rd_cnt_q < PixMax) begin
          pop_in   = 1'b1;
          ff_in_en = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        // Only fully interior windows produce a result; edge and row-wrap windows are dropped.
        if (dv_q[WIN_LAT-1] && (drow_q[WIN_LAT-1] >= KEdge) && (dcol_q[WIN_LAT-1] >= KEdge)
            && (push_cnt_q < OutMax)) begin
          ff_out_en  = 1'b1;
          ff_out_pp  = 1'b1;
          push_cnt_d = push_cnt_q + 1'b1;
          if (push_cnt_d == OutMax) state_d = StDrain;
        end
        if (bus.conv_done) err_d = 1'b1;
      end
      StDrain: begin
        if (bus.out_ready && (pop_cnt_q < OutMax)) begin
          pop_out   = 1'b1;
          ff_out_en = 1'b1;
          pop_cnt_d = pop_cnt_q + 1'b1;
        end
        // Registered check leaves one cycle for the final out_valid before DONE.
        if (pop_cnt_q == OutMax) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      in_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      push_cnt_q  <= '0;
      pop_cnt_q   <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      push_cnt_q  <= push_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      err_q       <= err_d;
      out_valid_q <= pop_out;
    end
  end

  // Coordinates of the popped pixel, delayed to line up with the window position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
      dv_q  <= '0;
      for (int i = 0; i < WIN_LAT; i++) begin
        drow_q[i] <= '0;
        dcol_q[i] <= '0;
      end
    end else if (clear) begin
      row_q <= '0;
      col_q <= '0;
      dv_q  <= '0;
      for (int i = 0; i < WIN_LAT; i++) begin
        drow_q[i] <= '0;
        dcol_q[i] <= '0;
      end
    end else begin
      if (pop_in) begin
        if (col_q == ColLast) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      dv_q[0]   <= pop_in;
      drow_q[0] <= row_q;
      dcol_q[0] <= col_q;
      for (int i = 1; i < WIN_LAT; i++) begin
        dv_q[i]   <= dv_q[i-1];
        drow_q[i] <= drow_q[i-1];
        dcol_q[i] <= dcol_q[i-1];
      end
    end
  end

`ifdef CONV_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
    end else if ((state_q == StIdle) && bus.start) begin
      cyc_q <= '0;
    end else if ((state_q != StIdle) && (cyc_q != '1)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycle_count = cyc_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.ff_in_en  = ff_in_en;
  assign bus.ff_in_pp  = ff_in_pp;
  assign bus.ff_out_en = ff_out_en;
  assign bus.ff_out_pp = ff_out_pp;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_convolution_controller.sv
// Bench for convolution_controller on a 4x4 image, 3x3 kernel: per-cycle comparison
// against a counter/queue model of the image flow, with randomized handshakes.
module tb_convolution_controller;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int KS   = 3;
  localparam int WL   = 1;
  localparam int PIX  = W * H;
  localparam int OUTN = (W - KS + 1) * (H - KS + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  convolution_controller_if cif ();
`ifdef CONV_CYCLE_CNT_EN
  logic [31:0] cycle_count;
`endif

  convolution_controller #(
    .IMG_W   (W),
    .IMG_H   (H),
    .K       (KS),
    .WIN_LAT (WL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cif.master)
`ifdef CONV_CYCLE_CNT_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model of one image: counts of pixels moved through each stage.
  bit active, ov_exp, err_m, seen_done;
  int m_in, m_pop, m_push, m_opop, since, bcnt, n_ov;
  int hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear(input bit act);
    active = act;
    ov_exp = 1'b0;
    err_m  = 1'b0;
    m_in = 0; m_pop = 0; m_push = 0; m_opop = 0; since = 0; bcnt = 0;
    hist = {};
    repeat (WL) hist.push_back(-1);
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_busy"}, cif.busy, 0);
    chk({t, "_in_ready"}, cif.in_ready, 0);
    chk({t, "_ff_in_en"}, cif.ff_in_en, 0);
    chk({t, "_ff_in_pp"}, cif.ff_in_pp, 0);
    chk({t, "_ff_out_en"}, cif.ff_out_en, 0);
    chk({t, "_ff_out_pp"}, cif.ff_out_pp, 0);
    chk({t, "_out_valid"}, cif.out_valid, 0);
    chk({t, "_done"}, cif.done, 0);
    chk({t, "_err"}, cif.err, 0);
`ifdef CONV_CYCLE_CNT_EN
    chk({t, "_cycle_count"}, cycle_count, 0);
`endif
  endtask

  // Samples one cycle mid-period, compares, then advances the model across the edge.
  task automatic cycle();
    bit loading, conv, e_inpush, e_pop, e_opush, e_opop, e_done, was_active;
    int d, idx;
    @(negedge clk);
    loading  = active && (m_in < PIX);
    conv     = active && (m_in == PIX) && (m_push < OUTN);
    e_inpush = loading && cif.in_valid;
    e_pop    = conv && (m_pop < PIX);
    d        = hist[0];
    e_opush  = conv && (d >= 0) && ((d / W) >= KS - 1) && ((d % W) >= KS - 1);
    e_opop   = active && (m_push == OUTN) && (m_opop < OUTN) && cif.out_ready;
    e_done   = active && (since == 2);
    chk("busy", cif.busy, active);
    chk("in_ready", cif.in_ready, loading);
    chk("ff_in_en", cif.ff_in_en, e_inpush || e_pop);
    chk("ff_in_pp", cif.ff_in_pp, e_inpush);
    chk("ff_out_en", cif.ff_out_en, e_opush || e_opop);
    chk("ff_out_pp", cif.ff_out_pp, e_opush);
    chk("out_valid", cif.out_valid, ov_exp);
    chk("done", cif.done, e_done);
    chk("err", cif.err, err_m);
`ifdef CONV_CYCLE_CNT_EN
    chk("cycle_count", cycle_count, bcnt);
`endif
    if (cif.out_valid === 1'b1) n_ov++;
    if (cif.done === 1'b1) seen_done = 1'b1;

    was_active = active;
    idx = m_pop;
    if (loading && cif.get_1_pic_done && (m_in < PIX - 1)) err_m = 1'b1;
    if (conv && cif.conv_done) err_m = 1'b1;
    ov_exp = e_opop;
    if (e_done) begin
      active = 1'b0;
      since  = 0;
    end else if (since > 0) begin
      since++;
    end else if (e_opop && (m_opop == OUTN - 1)) begin
      since = 1;
    end
    if (e_inpush) m_in++;
    if (e_pop) m_pop++;
    if (e_opush) m_push++;
    if (e_opop) m_opop++;
    void'(hist.pop_front());
    hist.push_back(e_pop ? idx : -1);
    if (was_active) bcnt++;
    if (!was_active && cif.start) model_clear(1'b1);
    @(posedge clk);
    #1;
  endtask

  // iv_mode: 0 always valid, 1 alternating, 2 random. or_mode: 0 ready, 1 random, 2 hold 0
  // for 10 drain cycles. stop_pop >= 0 returns early once that many pixels were popped.
  task automatic run_image(input int iv_mode, input int or_mode, input int g1p_at,
                           input bit start_in_load, input bit cd_early, input int stop_pop);
    int held;
    bit fin;
    bit ld, dr;
    held = 0;
    fin  = 1'b0;
    seen_done = 1'b0;
    n_ov = 0;
    cif.start = 1'b1;
    cif.in_valid = 1'b0;
    cif.out_ready = 1'b0;
    cif.get_1_pic_done = 1'b0;
    cif.conv_done = 1'b0;
    cycle();
    cif.start = 1'b0;
    for (int n = 0; n < 600 && !fin; n++) begin
      ld = active && (m_in < PIX);
      dr = active && (m_push == OUTN);
      case (iv_mode)
        0:       cif.in_valid = 1'b1;
        1:       cif.in_valid = (n % 2 == 0);
        default: cif.in_valid = 1'($urandom);
      endcase
      case (or_mode)
        0: cif.out_ready = 1'b1;
        1: cif.out_ready = 1'($urandom);
        default: begin
          cif.out_ready = dr && (held >= 10);
          if (dr && held < 10) held++;
        end
      endcase
      cif.get_1_pic_done = ld && (m_in == g1p_at);
      cif.start = start_in_load && ld && (m_in == 5);
      cif.conv_done = dr || (cd_early && active && (m_in == PIX) && (m_pop == 8));
      if (stop_pop >= 0 && m_pop == stop_pop) begin
        fin = 1'b1;
      end else begin
        cycle();
        if (seen_done) fin = 1'b1;
      end
    end
    cif.start = 1'b0;
    cif.in_valid = 1'b0;
    cif.out_ready = 1'b0;
    cif.get_1_pic_done = 1'b0;
    cif.conv_done = 1'b0;
    if (stop_pop < 0) begin
      chk("done_seen", seen_done, 1);
      chk("out_valid_total", n_ov, OUTN);
    end
  endtask

  initial begin
    cif.start = 1'b0;
    cif.in_valid = 1'b0;
    cif.out_ready = 1'b0;
    cif.get_1_pic_done = 1'b0;
    cif.conv_done = 1'b0;
    model_clear(1'b0);
    #1;
    chk_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle();
    cycle();

    // T1: error raised during LOAD, then reset lands in the middle of CONV
    run_image(0, 0, 2, 1'b0, 1'b0, 3);
    chk("t1_busy_pre", cif.busy, 1);
    chk("t1_err_pre", cif.err, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("t1_async");
    model_clear(1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle();

    // T2: full image, continuous valid/ready
    run_image(0, 0, -1, 1'b0, 1'b0, -1);
    // T3: alternating in_valid
    run_image(1, 0, -1, 1'b0, 1'b0, -1);
    // T4: random in_valid, out_ready held low for 10 drain cycles
    run_image(2, 2, -1, 1'b0, 1'b0, -1);
    // T5: start during LOAD ignored; early input-FIFO full flag
    run_image(0, 1, 5, 1'b1, 1'b0, -1);
    chk("t5_err", cif.err, 1);
    // Output FIFO full flag before the final push, random handshakes
    run_image(2, 1, -1, 1'b0, 1'b1, -1);
    chk("t7_err", cif.err, 1);
    // T6 / idle hold: counter and status keep their values after done
    repeat (3) cycle();
`ifdef CONV_CYCLE_CNT_EN
    chk("t6_cycle_hold", cycle_count, bcnt);
`endif
    run_image(2, 1, -1, 1'b0, 1'b0, -1);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
